decled_enc: RTL and testbench

- Reverse path of the LED pattern decoder.
- Takes an 8-bit active-low LED/switch pattern from a front-panel jumper/DIP header or loopback, synchronises and debounces it, then maps it back to the 4-bit code using the same table.
- Presents each newly stable pattern once on a valid/ready handshake to a downstream consumer, e.g. a UART reporter or self-test checker.

---
 rtl/decled_enc.sv | 130 +++++++++++++
 tb/tb_decled_enc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/decled_enc.sv
// decled_enc: LED/switch pattern to 4-bit code encoder (reverse LED decode).
// Syncs and debounces an active-low pattern, reports each new one once.
// Ports: clk, rst (async high), pat_n[7:0] in; code_o[3:0], err_o,
//   valid_o, busy_o out; ready_i in; err_cnt_o[7:0] out (optional).
// Optional: define DECLED_ENC_ERRCNT_EN for a saturating error counter.
module decled_enc #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pat_n,
    output logic [3:0] code_o,
    output logic       err_o,
    output logic       valid_o,
    input  logic       ready_i,
`ifdef DECLED_ENC_ERRCNT_EN
    output logic [7:0] err_cnt_o,
`endif
    output logic       busy_o
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state;
    logic [7:0]    s1;
    logic [7:0]    s2;
    logic [7:0]    cand;
    logic [7:0]    last;
    logic [CW-1:0] cnt;
    logic          have_last;

    // {err, code}
    function automatic logic [4:0] lookup(input logic [7:0] p);
        logic [4:0] r;
        r = 5'h10;
        unique case (p)
            8'hFF: r = 5'h00;
            8'hFE: r = 5'h01;
            8'hFC: r = 5'h02;
            8'hF9: r = 5'h03;
            8'hF3: r = 5'h04;
            8'hE7: r = 5'h05;
            8'hCF: r = 5'h06;
            8'h9F: r = 5'h07;
            8'h3F: r = 5'h08;
            8'h7F: r = 5'h09;
            8'h55: r = 5'h0A;
            8'h54: r = 5'h0B;
            8'h53: r = 5'h0C;
            8'h52: r = 5'h0D;
            8'h51: r = 5'h0E;
            8'h50: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SETTLE;
            s1        <= 8'hFF;
            s2        <= 8'hFF;
            cand      <= 8'hFF;
            last      <= 8'hFF;
            cnt       <= '0;
            have_last <= 1'b0;
            code_o    <= 4'h0;
            err_o     <= 1'b0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b1;
`ifdef DECLED_ENC_ERRCNT_EN
            err_cnt_o <= 8'h00;
`endif
        end else begin
            s1 <= pat_n;
            s2 <= s1;
            unique case (state)
                SETTLE: begin
                    if (s2 != cand) begin
                        cand <= s2;
                        cnt  <= '0;
                    end else if (cnt != CMAX) begin
                        cnt <= cnt + CW'(1);
                    end else if (have_last && cand == last) begin
                        // settled back on what was last reported
                        state  <= HOLD;
                        busy_o <= 1'b0;
                    end else begin
                        {err_o, code_o} <= lookup(cand);
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready_i) begin
                        last      <= cand;
                        have_last <= 1'b1;
                        valid_o   <= 1'b0;
                        state     <= HOLD;
`ifdef DECLED_ENC_ERRCNT_EN
                        if (err_o && err_cnt_o != 8'hFF)
                            err_cnt_o <= err_cnt_o + 8'd1;
`endif
                    end
                end
                HOLD: begin
                    if (s2 != last) begin
                        cand   <= s2;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= SETTLE;
                    end
                end
                default: begin
                    state  <= SETTLE;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decled_enc.sv
// tb_decled_enc: randomized and directed checks of decled_enc against
// a table-driven reference of which patterns get reported and when.
module tb_decled_enc;

    localparam int S = 16;

    localparam logic [7:0] TBL [16] = '{
        8'hFF, 8'hFE, 8'hFC, 8'hF9, 8'hF3, 8'hE7, 8'hCF, 8'h9F,
        8'h3F, 8'h7F, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h50
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pat_n = 8'hFF;
    logic       ready_i = 1'b1;
    logic [3:0] code_o;
    logic       err_o;
    logic       valid_o;
    logic       busy_o;
`ifdef DECLED_ENC_ERRCNT_EN
    logic [7:0] err_cnt_o;
`endif

    decled_enc #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_n     (pat_n),
        .code_o    (code_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
`ifdef DECLED_ENC_ERRCNT_EN
        .err_cnt_o (err_cnt_o),
`endif
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt++;

    int nassert = 0;
    int nfail = 0;

    // reference state: last reported pattern, error report count
    int         have_last = 0;
    logic [7:0] last_rep = 8'hFF;
    int         m_errcnt = 0;

    // observations of a watch window
    int         npulse;
    logic [3:0] g_code;
    logic       g_err;
    logic       g_busy;
    int         g_time;

    function automatic logic [4:0] ref_map(input logic [7:0] p);
        for (int i = 0; i < 16; i++)
            if (TBL[i] == p) return {1'b0, 4'(i)};
        return 5'h10;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic watch(input int n);
        npulse = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                if (npulse == 0) begin
                    g_code = code_o;
                    g_err  = err_o;
                    g_busy = busy_o;
                    g_time = ecnt;
                end
                npulse++;
            end
        end
    endtask

    task automatic chk_errcnt(input string tag);
`ifdef DECLED_ENC_ERRCNT_EN
        chk(tag, 32'(err_cnt_o), 32'(m_errcnt));
`else
        chk(tag, 32'(valid_o), 32'(1'b0));
`endif
    endtask

    // drive p at a negedge, hold n cycles, check against the reference
    task automatic apply(input logic [7:0] p, input int n);
        int t0;
        logic exp_rep;
        logic [4:0] e;
        pat_n = p;
        t0 = ecnt;
        exp_rep = (have_last == 0) || (p != last_rep);
        watch(n);
        chk($sformatf("npulse_%02h", p), 32'(npulse), 32'(exp_rep));
        if (exp_rep) begin
            e = ref_map(p);
            if (npulse > 0) begin
                chk($sformatf("code_%02h", p), 32'(g_code), 32'(e[3:0]));
                chk($sformatf("err_%02h", p), 32'(g_err), 32'(e[4]));
                chk($sformatf("lat_%02h", p), 32'(g_time - t0), 32'(S + 3));
                chk($sformatf("busy_%02h", p), 32'(g_busy), 32'(1'b0));
            end
            have_last = 1;
            last_rep = p;
            if (e[4] && m_errcnt < 255) m_errcnt++;
`ifdef DECLED_ENC_ERRCNT_EN
            chk($sformatf("errcnt_%02h", p), 32'(err_cnt_o), 32'(m_errcnt));
`endif
        end
    endtask

    initial begin
        int t0;
        int d;
        int bad;
        logic [7:0] p;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_code", 32'(code_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h1);
        chk_errcnt("rst_errcnt");

        // first stable pattern after reset is FF, reported once
        rst = 1'b0;
        t0 = ecnt;
        watch(40);
        d = g_time - t0;
        chk("first_npulse", 32'(npulse), 32'h1);
        chk("first_code", 32'(g_code), 32'h0);
        chk("first_err", 32'(g_err), 32'h0);
        chk("first_lat_ok", 32'(d >= S && d <= S + 2), 32'h1);
        have_last = 1;
        last_rep = 8'hFF;
        apply(8'hFF, 30);

        // directed table entries and an error pattern
        apply(8'hFE, 40);
        apply(8'hF9, 40);
        apply(8'h3F, 40);
        apply(8'h53, 40);
        apply(8'hAA, 40);

`ifdef DECLED_ENC_ERRCNT_EN
        for (int i = 0; i < 256; i++)
            apply((i % 2 == 0) ? 8'hAB : 8'hAA, S + 6);
        chk("errcnt_sat", 32'(err_cnt_o), 32'hFF);
`endif

        // glitch away and back to the last reported value
        apply(8'h7F, 40);
        pat_n = 8'hFE;
        watch(5);
        chk("hold_glitch_a", 32'(npulse), 32'h0);
        pat_n = 8'h7F;
        watch(40);
        chk("hold_glitch_b", 32'(npulse), 32'h0);

        // glitch while settling a new pattern restarts the count
        pat_n = 8'h3F;
        watch(5);
        chk("settle_glitch_a", 32'(npulse), 32'h0);
        pat_n = 8'hFE;
        watch(5);
        chk("settle_glitch_b", 32'(npulse), 32'h0);
        apply(8'h3F, 40);

        // backpressure: report stays frozen while pat_n moves
        ready_i = 1'b0;
        pat_n = 8'hFF;
        repeat (S + 3) @(negedge clk);
        chk("bp_valid", 32'(valid_o), 32'h1);
        chk("bp_code", 32'(code_o), 32'h0);
        pat_n = 8'hCF;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || code_o !== 4'h0 || err_o !== 1'b0)
                bad++;
        end
        chk("bp_frozen", 32'(bad), 32'h0);
        ready_i = 1'b1;
        t0 = ecnt;
        watch(30);
        chk("bp_npulse", 32'(npulse), 32'h1);
        chk("bp_cf_code", 32'(g_code), 32'h6);
        chk("bp_cf_lat", 32'(g_time - t0), 32'(S + 2));
        last_rep = 8'hCF;

        // reset while a report is pending
        ready_i = 1'b0;
        pat_n = 8'h50;
        repeat (S + 3) @(negedge clk);
        chk("mid_valid", 32'(valid_o), 32'h1);
        chk("mid_code", 32'(code_o), 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h1);
        chk("mid_rst_code", 32'(code_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        have_last = 0;
        m_errcnt = 0;
        chk_errcnt("mid_rst_errcnt");
        apply(8'h50, 40);

        // randomized patterns, table entries and arbitrary bytes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0)
                p = TBL[$urandom_range(0, 15)];
            else
                p = 8'($urandom);
            apply(p, S + 5 + int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nassert, nfail);
        $finish;
    end

endmodule
